// File: rtl/execute_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_unit_if
// Description : Decoder-to-execute-unit bundle: operation controls in,
//               accumulator / register / status results out.
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_unit_if #(
    parameter int DATA_W  = 8,
    parameter int REG_NUM = 8
);
    localparam int c_ADDR_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    logic [3:0]          alu_instruction_code;
    logic                acumulator_ce;
    logic                reg_file_ce;
    logic [c_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]   imm_data;
    logic [DATA_W-1:0]   acu_data;
    logic [DATA_W-1:0]   reg_data;
    logic                zero_flag;
    logic                carry_flag;
    logic                busy;

    modport master (
        output alu_instruction_code, acumulator_ce, reg_file_ce, reg_addr, imm_data,
        input  acu_data, reg_data, zero_flag, carry_flag, busy
    );

    modport slave (
        input  alu_instruction_code, acumulator_ce, reg_file_ce, reg_addr, imm_data,
        output acu_data, reg_data, zero_flag, carry_flag, busy
    );
endinterface
`default_nettype wire

// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : execute_unit
// Description : Accumulator ALU with register file and sequential shift-add
//               multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_unit #(
    parameter int DATA_W  = 8,
    parameter int REG_NUM = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    execute_unit_if.slave    bus
);
    localparam int c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);

    localparam logic [3:0] c_OP_LDI = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h3;
    localparam logic [3:0] c_OP_AND = 4'h4;
    localparam logic [3:0] c_OP_OR  = 4'h5;
    localparam logic [3:0] c_OP_XOR = 4'h6;
    localparam logic [3:0] c_OP_NOT = 4'h7;
    localparam logic [3:0] c_OP_SHL = 4'h8;
    localparam logic [3:0] c_OP_SHR = 4'h9;
    localparam logic [3:0] c_OP_LDR = 4'hA;
    localparam logic [3:0] c_OP_MUL = 4'hB;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MUL  = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;

    logic [DATA_W-1:0]   r_acc;
    logic                r_zero;
    logic                r_carry;
    logic [DATA_W-1:0]   r_regs [REG_NUM];

    logic [2*DATA_W-1:0] r_mcand;
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W-1:0]   r_mplier;
    logic [c_CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0]   w_reg_rd;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [2*DATA_W-1:0] w_prod_next;

    logic                w_acc_we;
    logic [DATA_W-1:0]   w_acc_next;
    logic                w_carry_next;
    logic                w_zero_next;
    logic                w_reg_we;
    logic                w_mul_start;
    logic                w_mul_step;

    assign w_reg_rd    = r_regs[bus.reg_addr];
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_reg_rd};
    // The extra MSB of the difference is the borrow for unsigned acc < reg.
    assign w_diff      = {1'b0, r_acc} - {1'b0, w_reg_rd};
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_we     = 1'b0;
        w_acc_next   = r_acc;
        w_carry_next = r_carry;
        w_reg_we     = 1'b0;
        w_mul_start  = 1'b0;
        w_mul_step   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_reg_we = bus.reg_file_ce;
                if (bus.acumulator_ce) begin
                    case (bus.alu_instruction_code)
                        c_OP_LDI: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = bus.imm_data;
                            w_carry_next = 1'b0;
                        end
                        c_OP_ADD: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = w_sum[DATA_W-1:0];
                            w_carry_next = w_sum[DATA_W];
                        end
                        c_OP_SUB: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = w_diff[DATA_W-1:0];
                            w_carry_next = w_diff[DATA_W];
                        end
                        c_OP_AND: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = r_acc & w_reg_rd;
                            w_carry_next = 1'b0;
                        end
                        c_OP_OR: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = r_acc | w_reg_rd;
                            w_carry_next = 1'b0;
                        end
                        c_OP_XOR: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = r_acc ^ w_reg_rd;
                            w_carry_next = 1'b0;
                        end
                        c_OP_NOT: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = ~r_acc;
                            w_carry_next = 1'b0;
                        end
                        c_OP_SHL: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = r_acc << 1;
                            w_carry_next = r_acc[DATA_W-1];
                        end
                        c_OP_SHR: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = r_acc >> 1;
                            w_carry_next = r_acc[0];
                        end
                        c_OP_LDR: begin
                            w_acc_we     = 1'b1;
                            w_acc_next   = w_reg_rd;
                            w_carry_next = 1'b0;
                        end
                        c_OP_MUL: begin
                            w_mul_start  = 1'b1;
                            w_state_next = c_ST_MUL;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            c_ST_MUL: begin
                // One multiplier bit per cycle; the last step commits the product.
                w_mul_step = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_acc_we     = 1'b1;
                    w_acc_next   = w_prod_next[DATA_W-1:0];
                    w_carry_next = |w_prod_next[2*DATA_W-1:DATA_W];
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase

        w_zero_next = (w_acc_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_reg_we) begin
                r_regs[bus.reg_addr] <= r_acc;
            end
            if (w_acc_we) begin
                r_acc   <= w_acc_next;
                r_zero  <= w_zero_next;
                r_carry <= w_carry_next;
            end
            if (w_mul_start) begin
                r_mcand  <= {{DATA_W{1'b0}}, r_acc};
                r_mplier <= w_reg_rd;
                r_prod   <= '0;
                r_cnt    <= '0;
            end else if (w_mul_step) begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign bus.acu_data   = r_acc;
    assign bus.reg_data   = w_reg_rd;
    assign bus.zero_flag  = r_zero;
    assign bus.carry_flag = r_carry;
    assign bus.busy       = (r_state == c_ST_MUL);
endmodule
`default_nettype wire
